// File: rtl/note_tone_gen_pkg.sv
// Shared note codes, octave selects, mid-octave half-period counts and FSM
// states for the buzzer tone generator.
package note_tone_gen_pkg;

    localparam int unsigned PER_W = 19;

    localparam logic [2:0] N_SPACE = 3'd0;
    localparam logic [2:0] N_DO    = 3'd1;
    localparam logic [2:0] N_RE    = 3'd2;
    localparam logic [2:0] N_MI    = 3'd3;
    localparam logic [2:0] N_FA    = 3'd4;
    localparam logic [2:0] N_SO    = 3'd5;
    localparam logic [2:0] N_LA    = 3'd6;
    localparam logic [2:0] N_Q1    = 3'd7;

    localparam logic [1:0] OCT_LOW  = 2'd0;
    localparam logic [1:0] OCT_MID  = 2'd1;
    localparam logic [1:0] OCT_HIGH = 2'd2;

    // Mid-octave half periods in 100 MHz clocks; low octave doubles, high halves.
    localparam logic [PER_W-1:0] T_DO = 19'd191110;
    localparam logic [PER_W-1:0] T_RE = 19'd170265;
    localparam logic [PER_W-1:0] T_MI = 19'd151685;
    localparam logic [PER_W-1:0] T_FA = 19'd143172;
    localparam logic [PER_W-1:0] T_SO = 19'd127551;
    localparam logic [PER_W-1:0] T_LA = 19'd113636;
    localparam logic [PER_W-1:0] T_XI = 19'd101239;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/note_tone_gen_lut.sv
// Combinational (note code, octave) -> half-period lookup; space maps to 0.
module note_period_lut
    import note_tone_gen_pkg::*;
(
    input  logic [2:0]       code_i,
    input  logic [1:0]       octave_i,
    output logic [PER_W-1:0] half_period_o
);

    logic [PER_W-1:0] mid;

    always_comb begin
        case (code_i)
            N_DO:    mid = T_DO;
            N_RE:    mid = T_RE;
            N_MI:    mid = T_MI;
            N_FA:    mid = T_FA;
            N_SO:    mid = T_SO;
            N_LA:    mid = T_LA;
            N_Q1:    mid = T_XI;
            default: mid = '0;
        endcase
    end

    // Octave 3 is treated as mid.
    always_comb begin
        case (octave_i)
            OCT_LOW:  half_period_o = mid << 1;
            OCT_HIGH: half_period_o = mid >> 1;
            default:  half_period_o = mid;
        endcase
    end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave buzzer driver: registered note/octave/enable, tone divider and
// a fixed articulation gap between distinct consecutive notes.
module note_tone_gen
    import note_tone_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned GAP_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EN,
    input  logic [2:0] num_note,
    input  logic [1:0] octave,
    output logic       speaker,
    output logic       playing
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    generate
        if (GAP_CYCLES < 1 || CLK_HZ == 0) begin : g_bad_param
            $error("note_tone_gen: GAP_CYCLES and CLK_HZ must be non-zero");
        end
    endgenerate

    logic [2:0]       note_q;
    logic [1:0]       oct_q;
    logic             en_q;
    logic [2:0]       cur_note_q;
    logic [1:0]       cur_oct_q;
    state_e           state_q;
    logic [PER_W-1:0] div_q;
    logic [GAP_W-1:0] gap_q;
    logic             speaker_q;
    logic             playing_q;

    logic [2:0]       eff_note;
    logic [PER_W-1:0] period;

    assign eff_note = en_q ? note_q : N_SPACE;

    // While a tone holds, eff_note/oct_q equal the tone's own code, so one
    // lookup serves both the initial load and every reload.
    note_period_lut u_lut (
        .code_i        (eff_note),
        .octave_i      (oct_q),
        .half_period_o (period)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_q     <= N_SPACE;
            oct_q      <= OCT_MID;
            en_q       <= 1'b0;
            cur_note_q <= N_SPACE;
            cur_oct_q  <= OCT_MID;
            state_q    <= ST_IDLE;
            div_q      <= '0;
            gap_q      <= '0;
            speaker_q  <= 1'b0;
            playing_q  <= 1'b0;
        end else begin
            note_q <= num_note;
            oct_q  <= octave;
            en_q   <= EN;

            case (state_q)
                ST_IDLE: begin
                    div_q     <= '0;
                    gap_q     <= '0;
                    speaker_q <= 1'b0;
                    playing_q <= 1'b0;
                    if (eff_note != N_SPACE) begin
                        state_q    <= ST_TONE;
                        div_q      <= period;
                        speaker_q  <= 1'b1;
                        playing_q  <= 1'b1;
                        cur_note_q <= eff_note;
                        cur_oct_q  <= oct_q;
                    end
                end

                ST_TONE: begin
                    if (eff_note == N_SPACE) begin
                        state_q   <= ST_IDLE;
                        div_q     <= '0;
                        speaker_q <= 1'b0;
                        playing_q <= 1'b0;
                    end else if (eff_note != cur_note_q || oct_q != cur_oct_q) begin
                        state_q   <= ST_GAP;
                        div_q     <= '0;
                        gap_q     <= GAP_W'(GAP_CYCLES - 1);
                        speaker_q <= 1'b0;
                        playing_q <= 1'b0;
                    end else if (div_q == PER_W'(1)) begin
                        // Reload rather than wrap so every half period is exact.
                        div_q     <= period;
                        speaker_q <= ~speaker_q;
                    end else begin
                        div_q <= div_q - PER_W'(1);
                    end
                end

                ST_GAP: begin
                    speaker_q <= 1'b0;
                    playing_q <= 1'b0;
                    if (eff_note == N_SPACE) begin
                        state_q <= ST_IDLE;
                        gap_q   <= '0;
                    end else if (gap_q == '0) begin
                        state_q    <= ST_TONE;
                        div_q      <= period;
                        speaker_q  <= 1'b1;
                        playing_q  <= 1'b1;
                        cur_note_q <= eff_note;
                        cur_oct_q  <= oct_q;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    div_q     <= '0;
                    gap_q     <= '0;
                    speaker_q <= 1'b0;
                    playing_q <= 1'b0;
                end
            endcase
        end
    end

    assign speaker = speaker_q;
    assign playing = playing_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed + randomized bench for note_tone_gen against a timestamp-based
// tone model, plus a sweep of the period lookup.
module tb_note_tone_gen;

    localparam int GAP = 8;
    localparam int M_IDLE = 0;
    localparam int M_TONE = 1;
    localparam int M_GAP  = 2;

    logic       clk;
    logic       rst_n;
    logic       EN;
    logic [2:0] num_note;
    logic [1:0] octave;
    logic       speaker;
    logic       playing;

    logic [2:0]  lut_code;
    logic [1:0]  lut_oct;
    logic [18:0] lut_per;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int r_note, r_oct, r_en;
    int m_mode, m_start, m_h, m_code, m_oct, m_gap_end;

    note_tone_gen #(.CLK_HZ(100_000_000), .GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .EN       (EN),
        .num_note (num_note),
        .octave   (octave),
        .speaker  (speaker),
        .playing  (playing)
    );

    note_period_lut u_lut_ref (
        .code_i        (lut_code),
        .octave_i      (lut_oct),
        .half_period_o (lut_per)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_half(input int code, input int oct);
        int base;
        case (code)
            1: base = 191110;
            2: base = 170265;
            3: base = 151685;
            4: base = 143172;
            5: base = 127551;
            6: base = 113636;
            7: base = 101239;
            default: base = 0;
        endcase
        if (oct == 0) return base * 2;
        if (oct == 2) return base / 2;
        return base;
    endfunction

    function automatic logic exp_spk();
        if (m_mode != M_TONE) return 1'b0;
        return (((cyc - m_start) / m_h) % 2) == 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        r_note = 0;
        r_oct  = 1;
        r_en   = 0;
    endtask

    task automatic start_tone(input int eff);
        m_mode  = M_TONE;
        m_start = cyc;
        m_h     = ref_half(eff, r_oct);
        m_code  = eff;
        m_oct   = r_oct;
    endtask

    task automatic model_step();
        int eff;
        eff = (r_en != 0) ? r_note : 0;
        case (m_mode)
            M_IDLE: if (eff != 0) start_tone(eff);
            M_TONE: begin
                if (eff == 0) m_mode = M_IDLE;
                else if (eff != m_code || r_oct != m_oct) begin
                    m_mode    = M_GAP;
                    m_gap_end = cyc + GAP;
                end
            end
            default: begin
                if (eff == 0) m_mode = M_IDLE;
                else if (cyc == m_gap_end) start_tone(eff);
            end
        endcase
    endtask

    // One clock: advance the model at the edge, compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else begin
            model_step();
            r_note = int'(num_note);
            r_oct  = int'(octave);
            r_en   = int'(EN);
        end
        #1;
        check("speaker", 32'(speaker), 32'(exp_spk()));
        check("playing", 32'(playing), 32'(m_mode == M_TONE));
    endtask

    initial begin
        rst_n = 1'b0; EN = 1'b0; num_note = 3'd0; octave = 2'd1;
        lut_code = 3'd0; lut_oct = 2'd1;
        model_reset();
        #2;
        check("reset_speaker", 32'(speaker), 32'd0);
        check("reset_playing", 32'(playing), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // First note after idle: speaker rises on the second edge.
        EN = 1'b1; num_note = 3'd1; octave = 2'd1;
        tick();
        check("do_lat1", 32'(speaker), 32'd0);
        tick();
        check("do_rise", 32'(speaker), 32'd1);
        check("do_play", 32'(playing), 32'd1);
        repeat (300) tick();

        // la mid, then octave switch to high: gap of GAP clocks, then 56818.
        num_note = 3'd6;
        repeat (30) tick();
        octave = 2'd2;
        repeat (2) tick();
        check("oct_gap_start", 32'(playing), 32'd0);
        repeat (7) tick();
        check("oct_gap_last", 32'(playing), 32'd0);
        tick();
        check("la_hi_start", 32'(speaker), 32'd1);
        repeat (56817) tick();
        check("la_hi_before", 32'(speaker), 32'd1);
        tick();
        check("la_hi_toggle", 32'(speaker), 32'd0);

        // mi -> fa: exactly GAP silent clocks; holding fa never re-gaps.
        octave = 2'd1; num_note = 3'd3;
        repeat (12) tick();
        num_note = 3'd4;
        repeat (2) tick();
        check("fa_gap_start", 32'(playing), 32'd0);
        repeat (7) tick();
        check("fa_gap_last", 32'(playing), 32'd0);
        tick();
        check("fa_start", 32'(speaker), 32'd1);
        repeat (100) tick();
        check("fa_held", 32'(playing), 32'd1);

        EN = 1'b0;
        repeat (2) tick();
        check("en_off_spk", 32'(speaker), 32'd0);
        check("en_off_play", 32'(playing), 32'd0);
        repeat (5) tick();
        EN = 1'b1;
        repeat (2) tick();
        check("en_restart", 32'(speaker), 32'd1);

        // Code changes inside a gap, then space: back to idle, no tone.
        num_note = 3'd2;
        repeat (3) tick();
        num_note = 3'd5;
        repeat (2) tick();
        num_note = 3'd0;
        repeat (2) tick();
        check("gap_to_idle", 32'(playing), 32'd0);
        repeat (12) tick();
        check("gap_idle_hold", 32'(speaker), 32'd0);

        // Asynchronous reset in the middle of a half period.
        num_note = 3'd7; octave = 2'd0;
        repeat (200) tick();
        check("pre_rst_spk", 32'(speaker), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_spk", 32'(speaker), 32'd0);
        check("rst_play", 32'(playing), 32'd0);
        model_reset();
        num_note = 3'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("post_rst_idle", 32'(speaker), 32'd0);
        num_note = 3'd3;
        repeat (2) tick();
        check("post_rst_tone", 32'(speaker), 32'd1);

        for (int c = 0; c < 8; c++) begin
            for (int o = 0; o < 4; o++) begin
                lut_code = 3'(c);
                lut_oct  = 2'(o);
                #1;
                check($sformatf("lut_c%0d_o%0d", c, o), 32'(lut_per), 32'(ref_half(c, o)));
            end
        end

        // Random note/octave/enable segments, every cycle checked by the model.
        for (int s = 0; s < 80; s++) begin
            EN = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) != 0) num_note = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) octave = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 25)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
